trap_ctrl: RTL

//  Hardware consumer of the core's error/exception signals. It samples the
//  per-instruction flags at writeback, prioritises them and drives a 4-state
//  FSM: pipeline flush -> mepc/mcause/mtval write -> PC redirect to mtvec.
//  It also handles mret, redirecting to mepc. Sits between the WB stage, the
//  CSR file and the IFU PC mux.

---
 rtl/trap_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - WB trap/mret sequencer: flush, CSR write, PC redirect (option: TRAP_EBREAK_HALT_EN)
module trap_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_valid,
    output logic             exc_ready,
    input  logic [XLEN-1:0]  exc_pc,
    input  logic [31:0]      exc_inst,
    input  logic [XLEN-1:0]  exc_addr,
    input  logic             exc_is_store,
    input  logic             fetch_fault,
    input  logic             invalid_inst,
    input  logic             ebreak,
    input  logic             ecall,
    input  logic             access_fault,
    input  logic             mret,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mepc_in,
    output logic             flush,
    output logic             csr_wen,
    output logic [XLEN-1:0]  mepc_out,
    output logic [XLEN-1:0]  mcause_out,
    output logic [XLEN-1:0]  mtval_out,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             halt,
    output logic [CNT_W-1:0] trap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_CSR,
        S_REDIR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  tval_q;
    logic [3:0]       cause_q;
    logic             is_mret_q;
    logic             halt_q;

    logic             take_trap;
    logic             take_mret;
    logic             take_halt;
    logic [3:0]       cause_d;
    logic [XLEN-1:0]  tval_d;
    logic             accept;

    // Highest-priority flag wins; any trap source beats mret.
    always_comb begin
        take_trap = 1'b0;
        take_mret = 1'b0;
        take_halt = 1'b0;
        cause_d   = 4'd0;
        tval_d    = '0;
        if (fetch_fault) begin
            take_trap = 1'b1;
            cause_d   = 4'd1;
            tval_d    = exc_pc;
        end else if (invalid_inst) begin
            take_trap = 1'b1;
            cause_d   = 4'd2;
            tval_d    = XLEN'(exc_inst);
        end else if (ebreak) begin
`ifdef TRAP_EBREAK_HALT_EN
            take_halt = 1'b1;
`else
            take_trap = 1'b1;
            cause_d   = 4'd3;
            tval_d    = exc_pc;
`endif
        end else if (ecall) begin
            take_trap = 1'b1;
            cause_d   = 4'd11;
        end else if (access_fault) begin
            take_trap = 1'b1;
            cause_d   = exc_is_store ? 4'd7 : 4'd5;
            tval_d    = exc_addr;
        end else if (mret) begin
            take_mret = 1'b1;
        end
    end

    assign exc_ready = (state == S_IDLE) && !halt_q;
    assign accept    = exc_valid && exc_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && (take_trap || take_mret)) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = is_mret_q ? S_REDIR : S_CSR;
            S_CSR:   state_nxt = S_REDIR;
            S_REDIR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc_q      <= '0;
            tval_q    <= '0;
            cause_q   <= 4'd0;
            is_mret_q <= 1'b0;
            trap_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (accept && (take_trap || take_mret)) begin
                pc_q      <= exc_pc;
                tval_q    <= tval_d;
                cause_q   <= cause_d;
                is_mret_q <= take_mret;
            end
            if (state == S_CSR && trap_cnt != {CNT_W{1'b1}}) begin
                trap_cnt <= trap_cnt + 1'b1;
            end
        end
    end

`ifdef TRAP_EBREAK_HALT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else if (accept && take_halt) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign halt_q = 1'b0;
`endif

    assign halt = halt_q;

    // Pulses are masked by rst so an aborted trap never completes a write or redirect.
    always_comb begin
        flush          = 1'b0;
        csr_wen        = 1'b0;
        redirect_valid = 1'b0;
        mepc_out       = '0;
        mcause_out     = '0;
        mtval_out      = '0;
        redirect_pc    = '0;
        if (!rst) begin
            case (state)
                S_FLUSH: flush = 1'b1;
                S_CSR: begin
                    csr_wen    = 1'b1;
                    mepc_out   = pc_q;
                    mcause_out = XLEN'(cause_q);
                    mtval_out  = tval_q;
                end
                S_REDIR: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = is_mret_q ? mepc_in : {mtvec[XLEN-1:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

endmodule
